// File: rtl/delay_ctrl_pkg.sv
// Shared controller state encoding and default delay-line timing constants.
// Also used by the calibration logic so both agree on the sequencing phases.
package delay_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_QUIET,
        STEP,
        SETTLE,
        DONE
    } tap_state_t;

    localparam int DEF_N_TAPS     = 16;
    localparam int DEF_QUIET_CYC  = 8;
    localparam int DEF_SETTLE_CYC = 4;
    localparam int DEF_RESET_TAP  = 0;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus history flop; o_edge flags a change in the synced signal.
// Latency 2-3 clk from an input transition to o_edge; no backpressure.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_edge
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_hist <= 1'b0;
        end else begin
            r_meta <= i_sig;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign o_edge = r_sync ^ r_hist;

endmodule

// File: rtl/delay_tap_ctrl.sv
// Glitch-free tap sequencer: single steps toward target, each after a quiet window and followed by a settle wait.
// Each step costs QUIET_CYC+1+SETTLE_CYC cycles; req_ready is low for the whole request, nothing is queued.
module delay_tap_ctrl
    import delay_ctrl_pkg::*;
#(
    parameter int N_TAPS     = DEF_N_TAPS,
    parameter int TAP_W      = $clog2(N_TAPS),
    parameter int QUIET_CYC  = DEF_QUIET_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int RESET_TAP  = DEF_RESET_TAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [TAP_W-1:0] req_tap,
    input  logic             sig_in,
    output logic [TAP_W-1:0] tap_sel,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int               CNT_W       = $clog2(max2(QUIET_CYC, SETTLE_CYC) + 1);
    localparam logic [TAP_W-1:0] TAP_MAX     = TAP_W'(N_TAPS - 1);
    localparam logic [TAP_W-1:0] TAP_RST     = TAP_W'(RESET_TAP);
    localparam logic [CNT_W-1:0] QUIET_LAST  = CNT_W'(QUIET_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    tap_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [TAP_W-1:0] r_target, w_target_nxt;
    logic [TAP_W-1:0] r_tap, w_tap_nxt;
    logic             r_err, w_err_nxt;
    logic             w_edge;
    logic             w_req_oor;
    logic [TAP_W-1:0] w_req_clamped;

    sync_edge_det u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sig  (sig_in),
        .o_edge (w_edge)
    );

    // Compare in 32 bits so a power-of-two N_TAPS cannot wrap the limit to zero.
    assign w_req_oor     = 32'(req_tap) > 32'(N_TAPS - 1);
    assign w_req_clamped = w_req_oor ? TAP_MAX : req_tap;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_target_nxt = r_target;
        w_tap_nxt    = r_tap;
        w_err_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_target_nxt = w_req_clamped;
                    w_err_nxt    = w_req_oor;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = (w_req_clamped == r_tap) ? DONE : WAIT_QUIET;
                end
            end
            WAIT_QUIET: begin
                if (w_edge) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == QUIET_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = STEP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            STEP: begin
                w_tap_nxt   = (r_target > r_tap) ? r_tap + TAP_W'(1) : r_tap - TAP_W'(1);
                w_cnt_nxt   = '0;
                w_state_nxt = SETTLE;
            end
            SETTLE: begin
                // Edges are deliberately ignored here; the mux is still settling.
                if (r_cnt == SETTLE_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (r_tap == r_target) ? DONE : WAIT_QUIET;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_target <= TAP_RST;
            r_tap    <= TAP_RST;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_target <= w_target_nxt;
            r_tap    <= w_tap_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign tap_sel   = r_tap;
    assign busy      = (r_state != IDLE);
    assign req_ready = (r_state == IDLE);
    assign done      = (r_state == DONE);
    assign err       = r_err;

endmodule

// File: tb/tb_delay_tap_ctrl.sv
// Directed and randomized bench for delay_tap_ctrl against a window-based timing model.
// The model derives each step time from quiet windows in the driven sig_in history.
module tb_delay_tap_ctrl;

    localparam int N    = 16;
    localparam int TW   = 5;
    localparam int Q    = 8;
    localparam int S    = 4;
    localparam int RT   = 0;
    localparam int MAXH = 3000;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [TW-1:0] req_tap;
    logic          sig_in;
    logic [TW-1:0] tap_sel;
    logic          busy;
    logic          done;
    logic          err;

    int n_cmp;
    int n_bad;
    int model_tap;
    bit sig_lvl;
    // drv[k+4] is the sig_in level driven just after relative posedge k.
    bit drv [MAXH + 8];

    delay_tap_ctrl #(
        .N_TAPS     (N),
        .TAP_W      (TW),
        .QUIET_CYC  (Q),
        .SETTLE_CYC (S),
        .RESET_TAP  (RT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_tap   (req_tap),
        .sig_in    (sig_in),
        .tap_sel   (tap_sel),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int p, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        assert (got === expv) else begin
            n_bad++;
            $error("FAIL %s p=%0d observed=%0d expected=%0d", tag, p, got, expv);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".tap_sel"},   -1, 32'(tap_sel),   32'(model_tap));
        chk({tag, ".req_ready"}, -1, 32'(req_ready), 32'd1);
        chk({tag, ".busy"},      -1, 32'(busy),      32'd0);
        chk({tag, ".done"},      -1, 32'(done),      32'd0);
        chk({tag, ".err"},       -1, 32'(err),       32'd0);
    endtask

    // The controller sees a synchronized edge at posedge p when the levels driven after posedges p-4 and p-3 differ.
    function automatic bit edge_at(input int p);
        return drv[p + 1] != drv[p];
    endfunction

    // First posedge P >= b+Q-1 whose trailing Q posedges are all edge-free.
    function automatic int find_quiet(input int b);
        for (int pp = b + Q - 1; pp < MAXH; pp++) begin
            bit ok;
            ok = 1'b1;
            for (int q = pp - Q + 1; q <= pp; q++)
                if (edge_at(q)) ok = 1'b0;
            if (ok) return pp;
        end
        return MAXH;
    endfunction

    // mode 0: quiet, 1: toggle every 3 cycles for 50 cycles, 2: random toggles for 60 cycles.
    task automatic do_req(input int tgt_raw, input int mode, input int hold, input int stop_after);
        int tclamp, nsteps, dir, b, pk, e, h, nst;
        bit oor, lvl;
        int stepat[$];
        logic [TW-1:0] alt;

        oor    = tgt_raw > N - 1;
        tclamp = oor ? N - 1 : tgt_raw;
        dir    = (tclamp > model_tap) ? 1 : -1;
        nsteps = (tclamp > model_tap) ? tclamp - model_tap : model_tap - tclamp;
        alt    = TW'((tclamp + 3) % N);

        lvl = sig_lvl;
        for (int k = 0; k < 4; k++) drv[k] = sig_lvl;
        for (int k = 0; k < MAXH + 4; k++) begin
            if (mode == 1 && k < 50 && (k % 3) == 0) lvl = ~lvl;
            else if (mode == 2 && k < 60 && $urandom_range(0, 5) == 0) lvl = ~lvl;
            drv[k + 4] = lvl;
        end

        b = 1;
        e = 0;
        for (int j = 0; j < nsteps; j++) begin
            pk = find_quiet(b);
            stepat.push_back(pk + 1);
            e = pk + 1 + S;
            b = pk + 2 + S;
        end
        h = ((e > 66) ? e : 66) + 4;
        if (h > MAXH) h = MAXH;

        req_tap   = TW'(tgt_raw);
        req_valid = 1'b1;
        for (int p = 0; p <= h; p++) begin
            @(posedge clk);
            #1;
            sig_in    = drv[p + 4];
            req_valid = (hold != 0) && (p <= e);
            if (hold != 0) req_tap = alt;
            @(negedge clk);
            nst = 0;
            foreach (stepat[j]) if (stepat[j] <= p) nst++;
            chk("tap_sel",   p, 32'(tap_sel),   32'(model_tap + dir * nst));
            chk("done",      p, 32'(done),      32'(p == e));
            chk("busy",      p, 32'(busy),      32'(p <= e));
            chk("req_ready", p, 32'(req_ready), 32'(p > e));
            chk("err",       p, 32'(err),       32'(oor && p == 0));
            if (stop_after >= 0 && p >= stop_after) break;
        end
        req_valid = 1'b0;
        sig_lvl   = sig_in;
        if (stop_after < 0) model_tap = tclamp;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        model_tap = RT;
        sig_lvl   = 1'b0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_tap   = '0;
        sig_in    = 1'b0;

        #12;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check_idle("post_reset");
        end

        do_req(3, 0, 0, -1);
        do_req(20, 0, 0, -1);
        do_req(5, 0, 0, -1);
        do_req(4, 1, 0, -1);
        do_req(4, 0, 1, -1);
        do_req(9, 0, 1, -1);
        do_req(0, 0, 0, -1);

        // Abort a 0->6 move during the first settle window.
        do_req(6, 0, 0, Q + 3);
        #2;
        rst_n     = 1'b0;
        model_tap = RT;
        #1;
        check_idle("mid_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check_idle("after_abort");
        end
        do_req(2, 0, 0, -1);

        for (int i = 0; i < 8; i++) begin
            do_req(int'($urandom_range(0, 20)), int'($urandom_range(0, 1)) * 2,
                   int'($urandom_range(0, 1)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/delay_tap_ctrl.md
# delay_tap_ctrl

Sequencing controller for a tap-selectable delay line built from cascaded constant-delay stages. Accepts tap-change requests through a valid/ready handshake and moves the tap select one stage at a time, only while the delayed signal is quiet, with a settle interval after each step, so the delay-line output never glitches. Sits between the configuration/calibration logic and the tap multiplexer of the delay line.

## Interface
- `N_TAPS`, 16: number of selectable taps (≥2).
- `TAP_W`, `$clog2(N_TAPS)`: tap index width.
- `QUIET_CYC`, 8: required consecutive edge-free cycles on `sig_in` before each step (≥1).
- `SETTLE_CYC`, 4: wait cycles after each step (≥1).
- `RESET_TAP`, 0: tap index applied in reset (< N_TAPS).

- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  tap-change request valid.
- `req_ready`  out  1  controller can accept a request.
- `req_tap`  in  TAP_W  target tap index.
- `sig_in`  in  1  signal entering the delay line; asynchronous to `clk`.
- `tap_sel`  out  TAP_W  tap select driving the delay-line mux (registered).
- `busy`  out  1  request in progress.
- `done`  out  1  one-cycle pulse: target reached.
- `err`  out  1  one-cycle pulse: request out of range, clamped.

## Operation
- Reset values: `tap_sel`=RESET_TAP, `req_ready`=1, `busy`=0, `done`=0, `err`=0, state IDLE, counters 0, synchronizer flops 0.
- `sig_in` passes through a 2-FF synchronizer plus one history flop; `edge` = XOR of the last two synchronized samples.
- States:
  - IDLE: `req_ready`=1. On `req_valid`: latch target = min(`req_tap`, N_TAPS-1); `err` pulses next cycle if `req_tap` ≥ N_TAPS. Target == `tap_sel` -> DONE; else -> WAIT_QUIET with quiet counter cleared.
  - WAIT_QUIET: quiet counter increments on each edge-free cycle and clears on `edge`. Reaching QUIET_CYC -> STEP.
  - STEP (1 cycle): `tap_sel` ±1 toward target, registered at cycle end -> SETTLE with settle counter cleared.
  - SETTLE: SETTLE_CYC cycles; edges ignored. Then `tap_sel` == target -> DONE, else -> WAIT_QUIET (quiet re-qualified before every step).
  - DONE (1 cycle): `done`=1 -> IDLE.
- `busy`=1 in every state except IDLE; `req_ready`=0 whenever `busy`=1. Requests are not queued.
- `tap_sel` changes only at the end of STEP, by exactly one.
- Boundaries:
  - Target N_TAPS-1 or 0: no over- or under-step; the clamped target stops stepping.
  - Continuous toggling of `sig_in`: the controller stays in WAIT_QUIET indefinitely; there is no timeout.
  - Async reset mid-operation: `tap_sel` returns to RESET_TAP immediately; the request is discarded; no `done`.

## Timing
- Handshake completes on the rising edge where `req_valid`&&`req_ready`.
- For k steps with a quiet `sig_in` (synchronizer already settled), the accept edge is cycle 0.
  - Each step takes QUIET_CYC+1+SETTLE_CYC cycles.
  - `done` is high in cycle k·(QUIET_CYC+1+SETTLE_CYC)+1.
  - `req_ready` returns in the following cycle.
- Zero-step request: `done` in cycle 1, `req_ready` in cycle 2.
- Input-edge-to-`edge` latency: 2–3 `clk` cycles due to synchronization.

## Structure
- Package `delay_ctrl_pkg`: state enum (IDLE, WAIT_QUIET, STEP, SETTLE, DONE) and default timing constants, shared with the calibration logic.
- Sub-module `sync_edge_det`: 2-FF synchronizer, history flop, edge output, async active-low reset.

## Test plan
- Reset with `rst_n`=0 -> `tap_sel`=0, `req_ready`=1, `busy`/`done`/`err`=0; values hold after release.
- Quiet `sig_in`, request tap 3 from 0 (Q=8, S=4) -> `tap_sel` steps 1, 2, 3 at 13-cycle intervals; `done` in cycle 40.
- Request tap 20 with N_TAPS=16 -> `err` pulse in cycle 1, target clamped; `tap_sel` reaches 15 and stops.
- From tap 5, request tap 4 while `sig_in` toggles every 3 cycles for 50 cycles -> `tap_sel` holds at 5 until 8 quiet cycles follow the last edge, then 4, then `done`.
- Request tap equal to current `tap_sel` -> no `tap_sel` change; `done` in cycle 1; `req_valid` held during `busy` is not accepted.
- `rst_n` asserted during SETTLE of a 0->6 move -> `tap_sel` immediately 0, no `done`; a new request after release is accepted normally.
